// File: rtl/pdp8l_memcyc_pkg.sv
// pdp8l_memcyc_pkg: shared types and constants for the memory-cycle
// initiator (state encoding, ident word, ARM register indices).
package pdp8l_memcyc_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      START  = 4'd1,
      WAITRD = 4'd2,
      WAITRH = 4'd3,
      WAITMW = 4'd4,
      WAITMH = 4'd5
   } state_t;

   localparam logic [31:0] MEMCYC_IDENT = 32'h4D491001;

   localparam logic [1:0] REG_IDENT = 2'd0;
   localparam logic [1:0] REG_CYCLE = 2'd1;
   localparam logic [1:0] REG_STATE = 2'd2;
   localparam logic [1:0] REG_COUNT = 2'd3;

endpackage

// File: rtl/pdp8l_memcyc_init.sv
// pdp8l_memcyc_init: ARM-driven initiator for single PDP-8/L memory
// cycles (read-restore or write) against the extended-memory responder.
// Ports: CLOCK/RESET (sync, active-high); ARM bus armwrite, armraddr,
//   armwaddr, armwdata, armrdata; cycle bus memstart, memaddr, memwdat,
//   memrdat, _mrdone, _mwdone, brkfld, _bf_enab, _df_enab, _zf_enab,
//   exefet, jmpjms, _ea.
// Build option MEMCYC_SYNC_EN: adds a 2-flop synchronizer on _mrdone,
//   _mwdone and _ea for a real backplane (needs STARTW >= 3).
module pdp8l_memcyc_init
   import pdp8l_memcyc_pkg::*;
#(
   parameter int STARTW  = 10,
   parameter int TIMEOUT = 255
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        armwrite,
   input  logic [1:0]  armraddr,
   input  logic [1:0]  armwaddr,
   input  logic [31:0] armwdata,
   output logic [31:0] armrdata,
   output logic        memstart,
   output logic [11:0] memaddr,
   output logic [11:0] memwdat,
   input  logic [11:0] memrdat,
   input  logic        _mrdone,
   input  logic        _mwdone,
   output logic [2:0]  brkfld,
   output logic        _bf_enab,
   output logic        _df_enab,
   output logic        _zf_enab,
   output logic        exefet,
   output logic        jmpjms,
   input  logic        _ea
);

   localparam logic [7:0] START_LAST = 8'(STARTW - 1);
   localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [14:0] addr_q;
   logic [11:0] data_q;
   logic [11:0] rdbuf_q;
   logic [11:0] memwdat_q;
   logic        write_q;
   logic        timeout_q;
   logic        eaerr_q;
   logic [15:0] count_q;
   logic        mrq_q, mwq_q;
   logic        mr_s, mw_s, ea_s;
   logic        busy;
   logic        wr_cyc;
   logic        wait_st;
   logic        ev;
   logic        abort;
   logic        unused_wdata;

   assign unused_wdata = ^armwdata[31:28];

`ifdef MEMCYC_SYNC_EN
   // Backplane strobes are asynchronous; two extra flops settle them.
   localparam logic [7:0] EA_CYC = 8'd2;
   logic [1:0] mr_sy_q, mw_sy_q, ea_sy_q;

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         mr_sy_q <= 2'b11;
         mw_sy_q <= 2'b11;
         ea_sy_q <= 2'b11;
      end else begin
         mr_sy_q <= {mr_sy_q[0], _mrdone};
         mw_sy_q <= {mw_sy_q[0], _mwdone};
         ea_sy_q <= {ea_sy_q[0], _ea};
      end
   end

   assign mr_s = mr_sy_q[1];
   assign mw_s = mw_sy_q[1];
   assign ea_s = ea_sy_q[1];
`else
   localparam logic [7:0] EA_CYC = 8'd0;
   assign mr_s = _mrdone;
   assign mw_s = _mwdone;
   assign ea_s = _ea;
`endif

   assign busy    = (state_q != IDLE);
   assign wr_cyc  = armwrite && (armwaddr == REG_CYCLE) && !busy;
   assign wait_st = (state_q == WAITRD) || (state_q == WAITRH) ||
                    (state_q == WAITMW) || (state_q == WAITMH);

   // Strobe condition that lets the current wait state advance.
   always_comb begin
      ev = 1'b0;
      unique case (1'b1)
         (state_q == WAITRD): ev = !mrq_q;
         (state_q == WAITRH): ev =  mrq_q;
         (state_q == WAITMW): ev = !mwq_q;
         (state_q == WAITMH): ev =  mwq_q;
         default:             ev = 1'b0;
      endcase
   end

   assign abort = wait_st && !ev && (cnt_q == TMO_LAST);

   // State register
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (wr_cyc) state_d = START;
         START:   if (cnt_q == START_LAST) state_d = WAITRD;
         WAITRD:  if (ev) state_d = WAITRH;
                  else if (abort) state_d = IDLE;
         WAITRH:  if (ev) state_d = WAITMW;
                  else if (abort) state_d = IDLE;
         WAITMW:  if (ev) state_d = WAITMH;
                  else if (abort) state_d = IDLE;
         WAITMH:  if (ev || abort) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // One counter serves both the start pulse width and the wait timeout:
   // it restarts on every state change.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)
         cnt_d = 8'd0;
      else if ((state_q == START) || wait_st)
         cnt_d = cnt_q + 8'd1;
   end

   // Outputs
   always_comb begin
      memstart = (state_q == START);
      _bf_enab = !busy;
      _df_enab = 1'b1;
      _zf_enab = 1'b1;
      exefet   = 1'b0;
      jmpjms   = 1'b0;
   end

   assign memaddr = addr_q[11:0];
   assign brkfld  = addr_q[14:12];
   assign memwdat = memwdat_q;

   // Cycle datapath
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         addr_q    <= 15'd0;
         data_q    <= 12'd0;
         rdbuf_q   <= 12'd0;
         memwdat_q <= 12'd0;
         write_q   <= 1'b0;
         timeout_q <= 1'b0;
         eaerr_q   <= 1'b0;
         count_q   <= 16'd0;
         mrq_q     <= 1'b1;
         mwq_q     <= 1'b1;
      end else begin
         mrq_q <= mr_s;
         mwq_q <= mw_s;
         if (wr_cyc) begin
            addr_q    <= armwdata[14:0];
            write_q   <= armwdata[15];
            data_q    <= armwdata[27:16];
            timeout_q <= 1'b0;
            eaerr_q   <= 1'b0;
         end
         // _ea high: the address falls in core, not block memory.
         if ((state_q == START) && (cnt_q == EA_CYC) && ea_s)
            eaerr_q <= 1'b1;
         if ((state_q == WAITRD) && ev) begin
            rdbuf_q   <= memrdat;
            memwdat_q <= write_q ? data_q : memrdat;
         end
         if ((state_q == WAITMH) && ev) begin
            if (!write_q)
               data_q <= rdbuf_q;
            count_q <= count_q + 16'd1;
         end
         if (abort)
            timeout_q <= 1'b1;
      end
   end

   // ARM read mux
   always_comb begin
      armrdata = 32'd0;
      unique case (armraddr)
         REG_IDENT: armrdata = MEMCYC_IDENT;
         REG_CYCLE: armrdata = {busy, timeout_q, eaerr_q, 1'b0,
                                data_q, write_q, addr_q};
         REG_STATE: armrdata = {20'd0, state_q, 8'd0};
         REG_COUNT: armrdata = {16'd0, count_q};
         default:   armrdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_pdp8l_memcyc_init.sv
// tb_pdp8l_memcyc_init: directed bench for pdp8l_memcyc_init with a
// small behavioural block-memory responder.
module tb_pdp8l_memcyc_init;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        armwrite = 1'b0;
   logic [1:0]  armraddr = 2'd0;
   logic [1:0]  armwaddr = 2'd0;
   logic [31:0] armwdata = 32'd0;
   logic [31:0] armrdata;
   logic        memstart;
   logic [11:0] memaddr;
   logic [11:0] memwdat;
   logic [11:0] memrdat = 12'd0;
   logic        mrdone_n = 1'b1;
   logic        mwdone_n = 1'b1;
   logic [2:0]  brkfld;
   logic        bf_enab_n, df_enab_n, zf_enab_n;
   logic        exefet, jmpjms;
   logic        ea_n = 1'b0;

   logic        resp_en = 1'b1;
   logic        hold_mw = 1'b0;
   logic [11:0] mw_seen = 12'd0;
   logic [11:0] mem [0:32767];

   int total = 0;
   int bad   = 0;

   pdp8l_memcyc_init dut (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .armwrite (armwrite),
      .armraddr (armraddr),
      .armwaddr (armwaddr),
      .armwdata (armwdata),
      .armrdata (armrdata),
      .memstart (memstart),
      .memaddr  (memaddr),
      .memwdat  (memwdat),
      .memrdat  (memrdat),
      ._mrdone  (mrdone_n),
      ._mwdone  (mwdone_n),
      .brkfld   (brkfld),
      ._bf_enab (bf_enab_n),
      ._df_enab (df_enab_n),
      ._zf_enab (zf_enab_n),
      .exefet   (exefet),
      .jmpjms   (jmpjms),
      ._ea      (ea_n)
   );

   always #5 CLOCK = ~CLOCK;

   // Responder: read strobe, then write strobe that stores memwdat.
   always begin
      logic [14:0] ra;
      @(posedge memstart);
      @(negedge CLOCK);
      ra = {brkfld, memaddr};
      if (resp_en) begin
         repeat (13) @(negedge CLOCK);
         memrdat  = mem[ra];
         mrdone_n = 1'b0;
         repeat (3) @(negedge CLOCK);
         mrdone_n = 1'b1;
         repeat (3) @(negedge CLOCK);
         if (!hold_mw) begin
            mw_seen  = memwdat;
            mem[ra]  = memwdat;
            mwdone_n = 1'b0;
            repeat (3) @(negedge CLOCK);
            mwdone_n = 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      armraddr = a;
      #1;
      d = armrdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      armwaddr = a;
      armwdata = d;
      armwrite = 1'b1;
      @(negedge CLOCK);
      armwrite = 1'b0;
   endtask

   task automatic wait_state(input logic [3:0] s, input int budget,
                             input string tag);
      logic [31:0] d;
      int n;
      n = 0;
      rd(2'd2, d);
      while ((d[11:8] != s) && (n < budget)) begin
         @(negedge CLOCK);
         n++;
         rd(2'd2, d);
      end
      check(tag, {28'd0, d[11:8]}, {28'd0, s});
   endtask

   initial begin
      logic [31:0] d;
      int w;

      for (int i = 0; i < 32768; i++) mem[i] = 12'd0;

      repeat (3) @(negedge CLOCK);
      RESET = 1'b0;

      // Reset state
      rd(2'd0, d); check("ident", d, 32'h4D491001);
      rd(2'd1, d); check("rst_reg1", d, 32'd0);
      rd(2'd2, d); check("rst_reg2", d, 32'd0);
      rd(2'd3, d); check("rst_count", d, 32'd0);
      check("rst_start", {31'd0, memstart}, 32'd0);
      check("rst_bf", {31'd0, bf_enab_n}, 32'd1);
      check("rst_pins", {27'd0, df_enab_n, zf_enab_n, exefet, jmpjms,
                         1'b0}, {27'd0, 5'b11000});
      check("rst_maddr", {20'd0, memaddr}, 32'd0);
      check("rst_wdat", {20'd0, memwdat}, 32'd0);
      check("rst_brk", {29'd0, brkfld}, 32'd0);

      // Read-restore of 0o12345 holding 0o7654
      mem[15'o12345] = 12'o7654;
      wr(2'd1, {4'd0, 12'd0, 1'b0, 15'o12345});
      rd(2'd2, d); check("rr_state", d, 32'h100);
      check("rr_bf", {31'd0, bf_enab_n}, 32'd0);
      check("rr_brk", {29'd0, brkfld}, 32'd1);
      check("rr_maddr", {20'd0, memaddr}, {20'd0, 12'o2345});
      w = 0;
      while (memstart && (w < 50)) begin
         w++;
         @(negedge CLOCK);
      end
      check("rr_width", w, 32'd10);
      wait_state(4'd0, 100, "rr_done");
      rd(2'd1, d);
      check("rr_reg1", d, {4'b0000, 12'o7654, 1'b0, 15'o12345});
      rd(2'd3, d); check("rr_count", d, 32'd1);
      check("rr_mem", {20'd0, mem[15'o12345]}, {20'd0, 12'o7654});

      // Write cycle 0o1234 -> 0o00017
      mem[15'o00017] = 12'o5555;
      wr(2'd1, {4'd0, 12'o1234, 1'b1, 15'o00017});
      wait_state(4'd0, 100, "wr_done");
      check("wr_mem", {20'd0, mem[15'o00017]}, {20'd0, 12'o1234});
      check("wr_mwdat", {20'd0, mw_seen}, {20'd0, 12'o1234});
      rd(2'd1, d);
      check("wr_reg1", d, {4'b0000, 12'o1234, 1'b1, 15'o00017});
      rd(2'd3, d); check("wr_count", d, 32'd2);

      // No responder: eaerr, then timeout
      resp_en = 1'b0;
      ea_n    = 1'b1;
      wr(2'd1, {4'd0, 12'o4321, 1'b0, 15'o00100});
      repeat (200) @(negedge CLOCK);
      rd(2'd1, d);
      check("to_busy", {29'd0, d[31:29]}, 32'd5);
      wait_state(4'd0, 100, "to_done");
      rd(2'd1, d);
      check("to_reg1", d, {4'b0110, 12'o4321, 1'b0, 15'o00100});
      rd(2'd3, d); check("to_count", d, 32'd2);
      check("to_bf", {31'd0, bf_enab_n}, 32'd1);
      check("to_wdat", {20'd0, memwdat}, {20'd0, 12'o1234});

      // Register-1 write while busy is dropped
      resp_en = 1'b1;
      ea_n    = 1'b0;
      mem[15'o31234] = 12'o0707;
      wr(2'd1, {4'd0, 12'd0, 1'b0, 15'o31234});
      check("bw_brk0", {29'd0, brkfld}, 32'd3);
      wait_state(4'd2, 50, "bw_waitrd");
      wr(2'd1, {4'd0, 12'o7777, 1'b1, 15'o00001});
      check("bw_brk1", {29'd0, brkfld}, 32'd3);
      check("bw_maddr", {20'd0, memaddr}, {20'd0, 12'o1234});
      wait_state(4'd0, 100, "bw_done");
      rd(2'd1, d);
      check("bw_reg1", d, {4'b0000, 12'o0707, 1'b0, 15'o31234});
      rd(2'd3, d); check("bw_count", d, 32'd3);
      check("bw_mem1", {20'd0, mem[15'o00001]}, 32'd0);

      // Reset while waiting for the write strobe
      hold_mw = 1'b1;
      wr(2'd1, {4'd0, 12'd0, 1'b0, 15'o12345});
      wait_state(4'd4, 100, "rs_waitmw");
      RESET = 1'b1;
      @(negedge CLOCK);
      check("rs_start", {31'd0, memstart}, 32'd0);
      check("rs_bf", {31'd0, bf_enab_n}, 32'd1);
      rd(2'd2, d); check("rs_state", d, 32'd0);
      rd(2'd3, d); check("rs_count", d, 32'd0);
      rd(2'd1, d); check("rs_reg1", d, 32'd0);
      check("rs_wdat", {20'd0, memwdat}, 32'd0);
      RESET   = 1'b0;
      hold_mw = 1'b0;
      @(negedge CLOCK);

      // Writes to read-only registers are ignored
      wr(2'd3, 32'hFFFF_FFFF);
      wr(2'd0, 32'h1234_5678);
      wr(2'd2, 32'h0000_0F00);
      rd(2'd3, d); check("ro_count", d, 32'd0);
      rd(2'd0, d); check("ro_ident", d, 32'h4D491001);
      rd(2'd2, d); check("ro_state", d, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pdp8l_memcyc_init.md
Name: pdp8l_memcyc_init

Overview:
- Initiator side of the PDP-8/L memory-cycle bus.
- Emulates the CPU so the ARM can run single read-restore or write cycles against the extended-memory responder without a real PDP-8/L attached.
- Drives memstart/memaddr/memwdat and break-field selects, then sequences on the _mrdone/_mwdone strobes.
- Sits beside the extended-memory block on the same ARM register bus; used for bring-up and self-test.

Parameters:
- STARTW, 10, memstart pulse width in CLOCK cycles (100 nS at 100 MHz).
- TIMEOUT, 255, maximum cycles to wait for any strobe edge before aborting.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- armwrite  in  1  ARM register write strobe
- armraddr  in  2  ARM read register select
- armwaddr  in  2  ARM write register select
- armwdata  in  32  ARM write data
- armrdata  out  32  ARM read data (combinational on armraddr)
- memstart  out  1  memory cycle start pulse to responder
- memaddr  out  12  address within field
- memwdat  out  12  write-back data
- memrdat  in  12  read data from responder
- _mrdone  in  1  active-low read-done strobe
- _mwdone  in  1  active-low write-done strobe
- brkfld  out  3  field for the cycle
- _bf_enab, _df_enab, _zf_enab  out  1 each  field-source selects
- exefet, jmpjms  out  1 each  held 0
- _ea  in  1  active-low extended-address indication from responder

Behaviour:
- Registers (all 32-bit):
  - [0] read-only ident = 32'h4D491001 ('MI', sizecode 1, version 001).
  - [1] write = {4'b0, data[27:16], write[15], addr[14:0]}; accepted only when state==IDLE, silently dropped otherwise.
  - [1] read = {busy, timeout, eaerr, 1'b0, data, write, addr}; data holds read data after a read-restore completes, otherwise the written data.
  - [2] read = {20'b0, state[3:0], 8'b0}.
  - [3] read = completed-cycle count; 16 bits, wraps 16'hFFFF->0, zero-extended.
  - Writes to 0, 2, 3 ignored.
- Outputs:
  - _bf_enab=0 throughout every cycle; 1 when idle.
  - _df_enab=_zf_enab=1 and exefet=jmpjms=0 at all times.
  - brkfld=addr[14:12], memaddr=addr[11:0].
- Strobe sampling: _mrdone/_mwdone registered once (mrq/mwq), active on registered low level.
- State machine:
  - IDLE: a register-1 write sets busy, clears timeout and eaerr, loads addr/data/write, goes to START next cycle.
  - START: memstart=1 for exactly STARTW cycles. On the first START cycle, latch eaerr=1 if _ea==1 (cycle would hit core, not block memory); the cycle still proceeds. Then go to WAITRD with memstart=0.
  - WAITRD: when mrq==0, capture rdbuf<=memrdat. memwdat<=write?data:memrdat; go to WAITRH.
  - WAITRH: wait mrq==1, then go to WAITMW.
  - WAITMW: wait mwq==0, then go to WAITMH.
  - WAITMH: wait mwq==1. Then: if ~write, data<=rdbuf; count++; busy=0; go to IDLE.
- Timeout: an 8-bit counter clears on each state entry and increments in every WAIT* state. Reaching TIMEOUT sets timeout=1, busy=0, memstart=0, _bf_enab=1 and returns to IDLE; data and count are unchanged.
- memwdat holds its value until the next cycle's WAITRD capture.
- armwrite in the same cycle as IDLE->START: no conflict, since the write is accepted only in IDLE.
- Reset, including mid-cycle: state=IDLE, memstart=0, memaddr=0, memwdat=0, brkfld=0, _bf_enab=1, busy=timeout=eaerr=0, count=0, data=addr=write=0.

Optional Feature:
- MEMCYC_SYNC_EN defined: _mrdone, _mwdone and _ea pass through a 2-flop synchronizer before the existing sample stage, for driving a real backplane. Each strobe edge costs +2 cycles; the eaerr sample moves to the third START cycle, so STARTW must be >=3.
- Not defined: single registered stage as described in Behaviour.

Decomposition:
- Package pdp8l_memcyc_pkg holds:
  - state enum: IDLE, START, WAITRD, WAITRH, WAITMW, WAITMH
  - ident constant and register-index constants
- No sub-module; the optional synchronizer is inline generate logic.

Test Plan:
- Paired with the extended-memory responder, lo4K enabled: ARM writes block memory 0o12345=0o7654; reg1 read-restore addr 0o12345 -> reg1 data=0o7654, busy=0, count=1, memory unchanged.
- Write cycle {data 0o1234, write, addr 0o00017} -> memory[0o17]=0o1234, memwdat=0o1234 at _mwdone, eaerr=0.
- Responder disabled (lo4K=0), field 0 -> eaerr=1, no strobes, timeout=1 after 255 waiting cycles, busy=0, count unchanged.
- Reg1 write while busy -> addr/data unchanged; cycle completes with original values.
- RESET asserted in WAITMW -> next cycle memstart=0, _bf_enab=1, state=IDLE, count=0.
- memstart high exactly 10 cycles; brkfld=3 for addr 0o31234 throughout the cycle.
